axi_hp_burst_writer: RTL and testbench

PL-side AXI4 write master that drives the processing system's high-performance slave port (s_axi_hp) to move a PL data stream into PS DDR. It accepts a command (start address, beat count), pulls data from a valid/ready stream, splits the transfer into INCR bursts that never cross a 4 KB boundary, and reports completion and response errors. It is the initiator for the PS HP slave and sits between PL datapath logic and the ps block.

---
 rtl/axi_hp_burst_writer.sv | 135 +++++++++++++
 tb/tb_axi_hp_burst_writer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_hp_burst_writer.sv
// AXI4 write master for the PS high-performance slave port: streams a PL beat
// sequence into DDR as INCR bursts that never straddle a 4 KB page.
module axi_hp_burst_writer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int MAX_BURST  = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [CNT_WIDTH-1:0]    cmd_beats,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [DATA_WIDTH-1:0]   s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic                    done,
  output logic                    err,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LSB   = $clog2(BYTES);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, RESP, DONE} state_t;

  state_t                r_state, w_nextState;
  logic [ADDR_WIDTH-1:0] r_addr, w_nextAddr;
  logic [CNT_WIDTH-1:0]  r_rem, w_nextRem;
  logic [8:0]            r_len, r_beatCnt, w_newLen;
  logic [7:0]            r_awLen;
  logic                  r_err;
  logic                  w_cmdHs, w_awHs, w_wHs, w_bHs, w_lastBeat;

  // Beats in the next burst: bounded by what is left, the burst cap and the
  // room remaining before the next 4 KB page (address is always beat-aligned).
  function automatic logic [8:0] calcLen(input logic [ADDR_WIDTH-1:0] a,
                                         input logic [CNT_WIDTH-1:0]  rem);
    logic [31:0] room;
    logic [31:0] len;
    room = (32'd4096 - {20'd0, a[11:0]}) >> LSB;
    len  = 32'(MAX_BURST);
    if (room < len) len = room;
    if (32'(rem) < len) len = 32'(rem);
    return len[8:0];
  endfunction

  assign w_cmdHs    = cmd_valid && cmd_ready;
  assign w_awHs     = (r_state == ADDR) && m_axi_awready;
  assign w_wHs      = (r_state == DATA) && s_valid && m_axi_wready;
  assign w_bHs      = (r_state == RESP) && m_axi_bvalid;
  assign w_lastBeat = (r_beatCnt == 9'd1);
  assign w_newLen   = calcLen(w_nextAddr, w_nextRem);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_nextAddr  = r_addr;
    w_nextRem   = r_rem;
    case (r_state)
      IDLE: if (w_cmdHs) begin
        w_nextAddr  = cmd_addr & ~ADDR_WIDTH'(BYTES - 1);
        w_nextRem   = cmd_beats;
        w_nextState = (cmd_beats == '0) ? DONE : ADDR;
      end
      ADDR: if (m_axi_awready) w_nextState = DATA;
      DATA: if (w_wHs && w_lastBeat) w_nextState = RESP;
      RESP: if (m_axi_bvalid) begin
        w_nextAddr  = r_addr + (ADDR_WIDTH'(r_len) << LSB);
        w_nextRem   = r_rem - CNT_WIDTH'(r_len);
        w_nextState = (w_nextRem == '0) ? DONE : ADDR;
      end
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Burst length is captured on every entry to ADDR so AW fields are stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr    <= '0;
      r_rem     <= '0;
      r_len     <= '0;
      r_awLen   <= '0;
      r_beatCnt <= '0;
      r_err     <= 1'b0;
    end else begin
      r_addr <= w_nextAddr;
      r_rem  <= w_nextRem;
      if (w_nextState == ADDR && r_state != ADDR) begin
        r_len   <= w_newLen;
        r_awLen <= 8'(w_newLen - 9'd1);
      end
      if (w_awHs)     r_beatCnt <= r_len;
      else if (w_wHs) r_beatCnt <= r_beatCnt - 9'd1;
      if (w_cmdHs)                             r_err <= 1'b0;
      else if (w_bHs && m_axi_bresp != 2'b00)  r_err <= 1'b1;
    end
  end

  assign cmd_ready     = (r_state == IDLE) && !rst;
  assign done          = (r_state == DONE);
  assign err           = r_err;
  assign m_axi_awaddr  = r_addr;
  assign m_axi_awlen   = r_awLen;
  assign m_axi_awsize  = 3'(LSB);
  assign m_axi_awburst = 2'b01;
  assign m_axi_awvalid = (r_state == ADDR);
  // The W channel is a straight pass-through of the stream while in DATA.
  assign m_axi_wvalid  = (r_state == DATA) && s_valid;
  assign s_ready       = (r_state == DATA) && m_axi_wready;
  assign m_axi_wdata   = (r_state == DATA) ? s_data : '0;
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = (r_state == DATA) && w_lastBeat;
  assign m_axi_bready  = (r_state == RESP);

endmodule

// File: tb/tb_axi_hp_burst_writer.sv
// Scoreboard bench for axi_hp_burst_writer: a reference burst splitter fills
// AW/W expectation queues, randomised AXI/stream responders drive the DUT.
module tb_axi_hp_burst_writer;

  logic        clk;
  logic        rst;
  logic [31:0] cmdAddr;
  logic [15:0] cmdBeats;
  logic        cmdValid, cmdReady;
  logic [63:0] sData;
  logic        sValid, sReady;
  logic        done, err;
  logic [31:0] awAddr;
  logic [7:0]  awLen;
  logic [2:0]  awSize;
  logic [1:0]  awBurst;
  logic        awValid, awReady;
  logic [63:0] wData;
  logic [7:0]  wStrb;
  logic        wLast, wValid, wReady;
  logic [1:0]  bResp;
  logic        bValid, bReady;

  axi_hp_burst_writer dut (
    .clk(clk), .rst(rst),
    .cmd_addr(cmdAddr), .cmd_beats(cmdBeats), .cmd_valid(cmdValid), .cmd_ready(cmdReady),
    .s_data(sData), .s_valid(sValid), .s_ready(sReady),
    .done(done), .err(err),
    .m_axi_awaddr(awAddr), .m_axi_awlen(awLen), .m_axi_awsize(awSize),
    .m_axi_awburst(awBurst), .m_axi_awvalid(awValid), .m_axi_awready(awReady),
    .m_axi_wdata(wData), .m_axi_wstrb(wStrb), .m_axi_wlast(wLast),
    .m_axi_wvalid(wValid), .m_axi_wready(wReady),
    .m_axi_bresp(bResp), .m_axi_bvalid(bValid), .m_axi_bready(bReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] addr; logic [7:0] len; } awExp_t;
  typedef struct packed { logic [63:0] data; logic last; } wExp_t;

  awExp_t      awQ[$];
  wExp_t       wQ[$];
  logic [63:0] srcData[$];
  logic [1:0]  respQ[$];
  int          srcIdx = 0;
  int          stallPct = 0;
  int          vectors = 0;
  int          miscompares = 0;
  int          wCnt = 0, doneCnt = 0, awValidCycles = 0;
  logic        sHsF = 0, bHsF = 0, wLastHsF = 0;
  int          bPending = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic waitCycle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: samples on the falling edge the handshakes that complete at the
  // next rising edge, and checks them against the expectation queues.
  initial begin
    logic        awPend, bPrev;
    logic [31:0] prevAddr;
    logic [7:0]  prevLen;
    awPend = 0; bPrev = 0; prevAddr = '0; prevLen = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        awPend = 0; bPrev = 0; sHsF = 0; bHsF = 0; wLastHsF = 0;
      end else begin
        if (awValid) awValidCycles++;
        if (awPend) begin
          checkOutput("awvalid_hold", 64'(awValid), 1);
          checkOutput("awaddr_stable", 64'(awAddr), 64'(prevAddr));
          checkOutput("awlen_stable", 64'(awLen), 64'(prevLen));
        end
        if (bPrev) begin
          if (awQ.size() > 0) checkOutput("b_to_aw_latency", 64'(awValid), 1);
          else                checkOutput("b_to_done_latency", 64'(done), 1);
        end
        if (awValid && awReady) begin
          checkOutput("aw_expected", 64'(awQ.size() > 0), 1);
          if (awQ.size() > 0) begin
            awExp_t e;
            e = awQ.pop_front();
            checkOutput("awaddr", 64'(awAddr), 64'(e.addr));
            checkOutput("awlen", 64'(awLen), 64'(e.len));
            checkOutput("awsize", 64'(awSize), 3);
            checkOutput("awburst", 64'(awBurst), 1);
            checkOutput("aw_4k", 64'((int'(awAddr[11:0]) + (int'(awLen) + 1) * 8) <= 4096), 1);
          end
        end
        if (wValid && wReady) begin
          wCnt++;
          checkOutput("w_expected", 64'(wQ.size() > 0), 1);
          if (wQ.size() > 0) begin
            wExp_t e;
            e = wQ.pop_front();
            checkOutput("wdata", wData, e.data);
            checkOutput("wlast", 64'(wLast), 64'(e.last));
            checkOutput("wstrb", 64'(wStrb), 64'hFF);
          end
        end
        if (done) doneCnt++;
        awPend   = awValid && !awReady;
        prevAddr = awAddr;
        prevLen  = awLen;
        bPrev    = bValid && bReady;
        sHsF     = sValid && sReady;
        bHsF     = bValid && bReady;
        wLastHsF = wValid && wReady && wLast;
      end
    end
  end

  // Responders: stream source, AW/W ready and B channel with random stalls.
  initial begin
    sValid = 0; sData = '0; awReady = 0; wReady = 0; bValid = 0; bResp = 2'b00;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        sValid = 0; awReady = 0; wReady = 0; bValid = 0; bPending = 0;
      end else begin
        if (sHsF) srcIdx++;
        if (!sValid || sHsF) begin
          if (srcIdx < srcData.size() && $urandom_range(99) >= stallPct) begin
            sValid = 1;
            sData  = srcData[srcIdx];
          end else begin
            sValid = 0;
          end
        end
        awReady = ($urandom_range(99) >= stallPct);
        wReady  = ($urandom_range(99) >= stallPct);
        if (wLastHsF) bPending++;
        if (bValid && bHsF) bValid = 0;
        if (!bValid && bPending > 0 && $urandom_range(99) >= stallPct) begin
          bValid = 1;
          bResp  = (respQ.size() > 0) ? respQ.pop_front() : 2'b00;
          bPending--;
        end
      end
    end
  end

  // Loads the reference bursts and stream data, then issues the command and
  // returns two time units after the accepting clock edge.
  task automatic applyStimulus(input logic [31:0] addr, input int beats, input int pct);
    logic [31:0] a;
    int          rem, len, room, n;
    logic        accepted;
    logic [63:0] d;
    a = addr & ~32'h7;
    rem = beats;
    srcData.delete();
    srcIdx = 0;
    stallPct = pct;
    while (rem > 0) begin
      room = (4096 - int'(a[11:0])) / 8;
      len = (rem < 16) ? rem : 16;
      if (room < len) len = room;
      awQ.push_back('{addr: a, len: 8'(len - 1)});
      for (int k = 0; k < len; k++) begin
        d = {$urandom, $urandom};
        srcData.push_back(d);
        wQ.push_back('{data: d, last: (k == len - 1)});
      end
      rem -= len;
      a += 32'(len * 8);
    end
    waitCycle();
    cmdAddr = addr;
    cmdBeats = 16'(beats);
    cmdValid = 1;
    n = 0;
    do begin
      accepted = cmdReady;
      waitCycle();
      n++;
    end while (!accepted && n < 50);
    checkOutput("cmd_accepted", 64'(accepted), 1);
    cmdValid = 0;
  endtask

  task automatic waitDone(input int start, input int limit);
    for (int i = 0; i < limit && doneCnt == start; i++) waitCycle();
    repeat (3) waitCycle();
  endtask

  task automatic checkResetOutputs(input string ph);
    checkOutput({ph, "_cmd_ready"}, 64'(cmdReady), 0);
    checkOutput({ph, "_awvalid"}, 64'(awValid), 0);
    checkOutput({ph, "_wvalid"}, 64'(wValid), 0);
    checkOutput({ph, "_s_ready"}, 64'(sReady), 0);
    checkOutput({ph, "_bready"}, 64'(bReady), 0);
    checkOutput({ph, "_done"}, 64'(done), 0);
    checkOutput({ph, "_err"}, 64'(err), 0);
    checkOutput({ph, "_awaddr"}, 64'(awAddr), 0);
    checkOutput({ph, "_awlen"}, 64'(awLen), 0);
    checkOutput({ph, "_wdata"}, wData, 0);
    checkOutput({ph, "_wlast"}, 64'(wLast), 0);
  endtask

  initial begin
    int d0, w0, a0;
    rst = 1; cmdAddr = '0; cmdBeats = '0; cmdValid = 0;
    repeat (3) waitCycle();
    checkResetOutputs("reset");
    rst = 0;
    waitCycle();
    checkOutput("idle_cmd_ready", 64'(cmdReady), 1);

    $display("[TB] three bursts of 16/16/8 beats");
    d0 = doneCnt; w0 = wCnt;
    applyStimulus(32'h1000_0000, 40, 0);
    checkOutput("t1_accept_to_awvalid", 64'(awValid), 1);
    checkOutput("t1_first_awaddr", 64'(awAddr), 64'h1000_0000);
    waitDone(d0, 500);
    checkOutput("t1_done_once", 64'(doneCnt - d0), 1);
    checkOutput("t1_w_beats", 64'(wCnt - w0), 40);
    checkOutput("t1_aw_drained", 64'(awQ.size()), 0);
    checkOutput("t1_err", 64'(err), 0);

    $display("[TB] 4 KB page split");
    d0 = doneCnt;
    applyStimulus(32'h1000_0FE0, 8, 0);
    waitDone(d0, 200);
    checkOutput("t2_done_once", 64'(doneCnt - d0), 1);
    checkOutput("t2_aw_drained", 64'(awQ.size()), 0);
    checkOutput("t2_w_drained", 64'(wQ.size()), 0);

    $display("[TB] zero-beat command");
    d0 = doneCnt; a0 = awValidCycles;
    applyStimulus(32'h1000_2000, 0, 0);
    checkOutput("t3_done_next_cycle", 64'(done), 1);
    waitCycle();
    checkOutput("t3_done_single", 64'(done), 0);
    repeat (3) waitCycle();
    checkOutput("t3_done_once", 64'(doneCnt - d0), 1);
    checkOutput("t3_no_awvalid", 64'(awValidCycles - a0), 0);

    $display("[TB] 100 beats with random stalls");
    d0 = doneCnt; w0 = wCnt;
    applyStimulus(32'h1000_3F00, 100, 40);
    waitDone(d0, 5000);
    checkOutput("t4_done_once", 64'(doneCnt - d0), 1);
    checkOutput("t4_w_beats", 64'(wCnt - w0), 100);
    checkOutput("t4_w_drained", 64'(wQ.size()), 0);

    $display("[TB] SLVERR on second burst");
    d0 = doneCnt;
    respQ = '{2'b00, 2'b10, 2'b00};
    applyStimulus(32'h1000_4000, 40, 20);
    waitDone(d0, 2000);
    checkOutput("t5_done_once", 64'(doneCnt - d0), 1);
    checkOutput("t5_err_sticky", 64'(err), 1);
    checkOutput("t5_w_drained", 64'(wQ.size()), 0);
    d0 = doneCnt;
    applyStimulus(32'h1000_5000, 4, 0);
    checkOutput("t5_err_cleared", 64'(err), 0);
    waitDone(d0, 200);
    checkOutput("t5b_done_once", 64'(doneCnt - d0), 1);
    checkOutput("t5b_err", 64'(err), 0);

    $display("[TB] reset during DATA");
    w0 = wCnt;
    applyStimulus(32'h2000_0000, 16, 0);
    for (int i = 0; i < 100 && (wCnt - w0) < 4; i++) waitCycle();
    checkOutput("t6_reached_beat5", 64'(wCnt - w0), 4);
    rst = 1;
    #1;
    checkResetOutputs("midreset");
    awQ.delete(); wQ.delete(); respQ.delete(); srcData.delete();
    repeat (2) waitCycle();
    rst = 0;
    waitCycle();
    checkOutput("t6_idle_after_release", 64'(cmdReady), 1);
    d0 = doneCnt; w0 = wCnt;
    applyStimulus(32'h3000_0040, 20, 30);
    checkOutput("t6_new_awaddr", 64'(awAddr), 64'h3000_0040);
    waitDone(d0, 2000);
    checkOutput("t6_done_once", 64'(doneCnt - d0), 1);
    checkOutput("t6_w_beats", 64'(wCnt - w0), 20);
    checkOutput("t6_err", 64'(err), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
